// File: rtl/set_associative_cache_if.sv
// set_associative_cache_if: fetch-side request, memory bus and arbiter signals of the I-cache
interface set_associative_cache_if #(
  parameter int BUS_DATA_WIDTH = 64,
  parameter int BUS_TAG_WIDTH  = 13,
  parameter int ADDRESS_WIDTH  = 64,
  parameter int DATA_WIDTH     = 32
);
  logic [ADDRESS_WIDTH-1:0]  addr;
  logic [1:0]                enable;
  logic [1:0]                rd_wr_evict_flag;
  logic [DATA_WIDTH-1:0]     read_data;
  logic [1:0]                data_available;
  logic                      bus_reqcyc;
  logic                      bus_reqack;
  logic [BUS_DATA_WIDTH-1:0] bus_req;
  logic [BUS_TAG_WIDTH-1:0]  bus_reqtag;
  logic                      bus_respcyc;
  logic                      bus_respack;
  logic [BUS_DATA_WIDTH-1:0] bus_resp;
  logic [BUS_TAG_WIDTH-1:0]  bus_resptag;
  logic                      addr_data_abtr_reqcyc;
  logic                      addr_data_abtr_grant;
  logic                      addr_data_bus_busy;
  logic                      store_data_abtr_reqcyc;
  logic                      store_data_abtr_grant;
  logic                      store_data_bus_busy;
  modport master (
    input  addr, enable, rd_wr_evict_flag, bus_reqack, bus_respcyc, bus_resp, bus_resptag,
           addr_data_abtr_grant, store_data_abtr_grant,
    output read_data, data_available, bus_reqcyc, bus_req, bus_reqtag, bus_respack,
           addr_data_abtr_reqcyc, addr_data_bus_busy, store_data_abtr_reqcyc, store_data_bus_busy
  );
  modport slave (
    output addr, enable, rd_wr_evict_flag, bus_reqack, bus_respcyc, bus_resp, bus_resptag,
           addr_data_abtr_grant, store_data_abtr_grant,
    input  read_data, data_available, bus_reqcyc, bus_req, bus_reqtag, bus_respack,
           addr_data_abtr_reqcyc, addr_data_bus_busy, store_data_abtr_reqcyc, store_data_bus_busy
  );
endinterface

// File: rtl/set_associative_cache.sv
// set_associative_cache: read-only 2-way I-cache, 64-byte lines filled by an 8-beat bus read.
// Defining CACHE_STATS_EN adds 32-bit hit_count / miss_count outputs.
module set_associative_cache #(
  parameter int BUS_DATA_WIDTH = 64,
  parameter int BUS_TAG_WIDTH  = 13,
  parameter int ADDRESS_WIDTH  = 64,
  parameter int DATA_WIDTH     = 32,
  parameter int NUM_SETS       = 64
) (
  input  logic clk,
  input  logic reset,
`ifdef CACHE_STATS_EN
  output logic [31:0] hit_count,
  output logic [31:0] miss_count,
`endif
  set_associative_cache_if.master cif
);
  localparam int IW = $clog2(NUM_SETS);
  localparam int TW = ADDRESS_WIDTH - 6 - IW;
  localparam int LW = 8 * BUS_DATA_WIDTH;
  localparam logic [BUS_TAG_WIDTH-1:0] RD_TAG = BUS_TAG_WIDTH'(13'h1100);
  localparam logic [1:0] IDLE = 2'd0, ARB = 2'd1, REQ = 2'd2, RESP = 2'd3;
  logic [1:0] state;
  logic [NUM_SETS-1:0] valid [2];
  logic [NUM_SETS-1:0] lru;
  logic [TW-1:0] tags [2][NUM_SETS];
  logic [LW-1:0] lines [2][NUM_SETS];
  logic [ADDRESS_WIDTH-7:0] miss_line;
  logic [IW-1:0] idx, miss_idx;
  logic [TW-1:0] tag;
  logic [2:0] beat;
  logic miss_way, hit0, hit1, hit, hit_way, victim, lookup, rd, ev, accept, unused;
  assign idx      = cif.addr[6 +: IW];
  assign tag      = cif.addr[ADDRESS_WIDTH-1 -: TW];
  assign miss_idx = miss_line[IW-1:0];
  assign hit0     = valid[0][idx] && tags[0][idx] == tag;
  assign hit1     = valid[1][idx] && tags[1][idx] == tag;
  assign hit      = hit0 | hit1;
  assign hit_way  = hit1;
  // lru[set] names the way to replace next
  assign victim   = !valid[0][idx] ? 1'b0 : !valid[1][idx] ? 1'b1 : lru[idx];
  assign lookup   = !reset && state == IDLE && cif.enable == 2'd2;
  assign rd       = lookup && cif.rd_wr_evict_flag == 2'd1;
  assign ev       = lookup && cif.rd_wr_evict_flag == 2'd3;
  assign accept   = state == RESP && cif.bus_respcyc && cif.bus_resptag == RD_TAG;
  assign unused   = ^{cif.addr[1:0], cif.store_data_abtr_grant};
  always_comb begin
    cif.read_data              = (rd && hit) ? lines[hit_way][idx][int'(cif.addr[5:2]) * DATA_WIDTH +: DATA_WIDTH] : '0;
    cif.data_available         = reset ? 2'd0 : state != IDLE ? 2'd1 : rd ? (hit ? 2'd2 : 2'd1) : ev ? 2'd2 : 2'd0;
    cif.bus_reqcyc             = state == REQ;
    cif.bus_req                = state == REQ ? BUS_DATA_WIDTH'({miss_line, 6'b0}) : '0;
    cif.bus_reqtag             = state == REQ ? RD_TAG : '0;
    cif.bus_respack            = accept;
    cif.addr_data_abtr_reqcyc  = state == ARB;
    cif.addr_data_bus_busy     = state == REQ || state == RESP;
    cif.store_data_abtr_reqcyc = 1'b0;
    cif.store_data_bus_busy    = 1'b0;
  end
  always_ff @(posedge clk)
    if (reset) begin
      state    <= IDLE;
      valid[0] <= '0;
      valid[1] <= '0;
      lru      <= '0;
      beat     <= '0;
    end else begin
      if (rd && hit) lru[idx] <= !hit_way;
      if (ev && hit) valid[hit_way][idx] <= 1'b0;
      if (rd && !hit) begin
        state                <= ARB;
        miss_line            <= cif.addr[ADDRESS_WIDTH-1:6];
        miss_way             <= victim;
        valid[victim][idx]   <= 1'b0;
        beat                 <= '0;
      end
      if (state == ARB && cif.addr_data_abtr_grant) state <= REQ;
      if (state == REQ && cif.bus_reqack) state <= RESP;
      if (accept) begin
        beat <= beat + 3'd1;
        if (beat == 3'd7) begin
          state                     <= IDLE;
          valid[miss_way][miss_idx] <= 1'b1;
          lru[miss_idx]             <= !miss_way;
        end
      end
    end
  // the victim stays invalid while it is refilled, so an abandoned fill never hits
  always_ff @(posedge clk) begin
    if (rd && !hit) tags[victim][idx] <= tag;
    if (accept) lines[miss_way][miss_idx][int'(beat) * BUS_DATA_WIDTH +: BUS_DATA_WIDTH] <= cif.bus_resp;
  end
`ifdef CACHE_STATS_EN
  always_ff @(posedge clk)
    if (reset) begin
      hit_count  <= '0;
      miss_count <= '0;
    end else begin
      if (rd && hit) hit_count <= hit_count + 32'd1;
      if (rd && !hit) miss_count <= miss_count + 32'd1;
    end
`else
  // no lookup counters in this build
`endif
endmodule

// File: tb/tb_set_associative_cache.sv
// tb_set_associative_cache: random reads/evicts/no-ops against a per-set recency-list model of the cache,
// with the bench acting as arbiter and memory.
module tb_set_associative_cache;
  localparam int NS = 64;
  logic clk = 1'b0, reset = 1'b1;
  always #5 clk = ~clk;
  set_associative_cache_if cif ();
`ifdef CACHE_STATS_EN
  logic [31:0] hit_count, miss_count;
`endif
  set_associative_cache dut (
    .clk(clk),
    .reset(reset),
`ifdef CACHE_STATS_EN
    .hit_count(hit_count),
    .miss_count(miss_count),
`endif
    .cif(cif)
  );
  int n_vec = 0, n_err = 0;
  logic [57:0] m_line [NS][2];
  int m_cnt [NS];
  int m_hits = 0, m_miss = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] beat_val(input logic [57:0] line, input int i);
    return (64'h11 * 64'(i + 1)) ^ (64'(line ^ 58'h40) << 20);
  endfunction

  function automatic logic [31:0] word_of(input logic [63:0] a);
    logic [63:0] v;
    v = beat_val(a[63:6], int'(a[5:3]));
    return a[2] ? v[63:32] : v[31:0];
  endfunction

  function automatic int find(input logic [63:0] a);
    int s = int'(a[11:6]);
    for (int i = 0; i < m_cnt[s]; i++) if (m_line[s][i] == a[63:6]) return i;
    return -1;
  endfunction

  task automatic m_remove(input int s, input int i);
    if (i == 0 && m_cnt[s] == 2) m_line[s][0] = m_line[s][1];
    m_cnt[s]--;
  endtask

  task automatic m_touch(input int s, input int i);
    logic [57:0] t;
    if (i == 0 && m_cnt[s] == 2) begin
      t = m_line[s][0];
      m_line[s][0] = m_line[s][1];
      m_line[s][1] = t;
    end
  endtask

  task automatic m_clear();
    for (int s = 0; s < NS; s++) m_cnt[s] = 0;
    m_hits = 0;
    m_miss = 0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_quiet(input string p);
    check({p, "_da"}, 64'(cif.data_available), 64'd0);
    check({p, "_rdata"}, 64'(cif.read_data), 64'd0);
    check({p, "_reqcyc"}, 64'(cif.bus_reqcyc), 64'd0);
    check({p, "_req"}, cif.bus_req, 64'd0);
    check({p, "_reqtag"}, 64'(cif.bus_reqtag), 64'd0);
    check({p, "_respack"}, 64'(cif.bus_respack), 64'd0);
    check({p, "_abtr"}, 64'(cif.addr_data_abtr_reqcyc), 64'd0);
    check({p, "_busy"}, 64'(cif.addr_data_bus_busy), 64'd0);
    check({p, "_store"}, 64'({cif.store_data_abtr_reqcyc, cif.store_data_bus_busy}), 64'd0);
  endtask

  task automatic req_checks(input logic [63:0] a);
    check("req_cyc", 64'(cif.bus_reqcyc), 64'd1);
    check("req_addr", cif.bus_req, {a[63:6], 6'b0});
    check("req_tag", 64'(cif.bus_reqtag), 64'h1100);
    check("req_busy", 64'(cif.addr_data_bus_busy), 64'd1);
    check("req_da", 64'(cif.data_available), 64'd1);
  endtask

  task automatic fill(input logic [63:0] a, input int abort_at);
    int s = int'(a[11:6]);
    int b = 0;
    int d;
    cif.addr = {$urandom, $urandom};
    d = $urandom_range(0, 2);
    repeat (d) begin
      @(negedge clk);
      check("arb_req", 64'(cif.addr_data_abtr_reqcyc), 64'd1);
      check("arb_da", 64'(cif.data_available), 64'd1);
      step();
    end
    cif.addr_data_abtr_grant = 1'b1;
    @(negedge clk);
    check("arb_req", 64'(cif.addr_data_abtr_reqcyc), 64'd1);
    check("arb_busy", 64'(cif.addr_data_bus_busy), 64'd0);
    step();
    cif.addr_data_abtr_grant = 1'b0;
    d = $urandom_range(0, 2);
    repeat (d) begin
      @(negedge clk);
      req_checks(a);
      step();
    end
    cif.bus_reqack = 1'b1;
    @(negedge clk);
    req_checks(a);
    step();
    cif.bus_reqack = 1'b0;
    for (int it = 0; it < 64 && b < 8; it++) begin
      int r = $urandom_range(0, 3);
      if (r == 0) begin
        cif.bus_respcyc = 1'b1;
        cif.bus_resptag = 13'h1100 ^ 13'($urandom_range(1, 8191));
        cif.bus_resp = {$urandom, $urandom};
        @(negedge clk);
        check("badtag_ack", 64'(cif.bus_respack), 64'd0);
        check("resp_reqcyc", 64'(cif.bus_reqcyc), 64'd0);
        step();
      end else if (r == 1) begin
        cif.bus_respcyc = 1'b0;
        step();
      end else begin
        cif.bus_respcyc = 1'b1;
        cif.bus_resptag = 13'h1100;
        cif.bus_resp = beat_val(a[63:6], b);
        @(negedge clk);
        check("beat_ack", 64'(cif.bus_respack), 64'd1);
        check("beat_busy", 64'(cif.addr_data_bus_busy), 64'd1);
        step();
        b++;
        if (b == abort_at) begin
          cif.bus_respcyc = 1'b0;
          cif.enable = 2'd0;
          reset = 1'b1;
          step();
          reset = 1'b0;
          @(negedge clk);
          check_quiet("abort");
          m_clear();
          step();
          return;
        end
      end
    end
    cif.bus_respcyc = 1'b0;
    cif.addr = a;
    @(negedge clk);
    check("fill_da", 64'(cif.data_available), 64'd2);
    check("fill_data", 64'(cif.read_data), 64'(word_of(a)));
    check("fill_busy", 64'(cif.addr_data_bus_busy), 64'd0);
    m_line[s][m_cnt[s]] = a[63:6];
    m_cnt[s]++;
    m_hits++;
    step();
  endtask

  task automatic rd(input logic [63:0] a, input int abort_at = 8);
    int s = int'(a[11:6]);
    int i = find(a);
    cif.addr = a;
    cif.enable = 2'd2;
    cif.rd_wr_evict_flag = 2'd1;
    @(negedge clk);
    if (i >= 0) begin
      check("hit_da", 64'(cif.data_available), 64'd2);
      check("hit_data", 64'(cif.read_data), 64'(word_of(a)));
      check("hit_noreq", 64'({cif.bus_reqcyc, cif.addr_data_abtr_reqcyc}), 64'd0);
      m_touch(s, i);
      m_hits++;
      step();
    end else begin
      check("miss_da", 64'(cif.data_available), 64'd1);
      check("miss_rdata", 64'(cif.read_data), 64'd0);
      m_miss++;
      if (m_cnt[s] == 2) m_remove(s, 0);
      step();
      fill(a, abort_at);
    end
  endtask

  task automatic evict(input logic [63:0] a);
    int i = find(a);
    cif.addr = a;
    cif.enable = 2'd2;
    cif.rd_wr_evict_flag = 2'd3;
    @(negedge clk);
    check("evict_da", 64'(cif.data_available), 64'd2);
    if (i >= 0) m_remove(int'(a[11:6]), i);
    step();
  endtask

  task automatic noop(input logic [63:0] a);
    cif.addr = a;
    if ($urandom_range(0, 1) == 1) begin
      cif.enable = 2'($urandom_range(0, 2));
      if (cif.enable == 2'd2) cif.enable = 2'd3;
      cif.rd_wr_evict_flag = 2'($urandom);
    end else begin
      cif.enable = 2'd2;
      cif.rd_wr_evict_flag = 2'($urandom_range(0, 1) * 2);
    end
    @(negedge clk);
    check("noop_da", 64'(cif.data_available), 64'd0);
    check("noop_rdata", 64'(cif.read_data), 64'd0);
    step();
  endtask

  function automatic logic [63:0] rand_addr();
    logic [51:0] t;
    case ($urandom_range(0, 3))
      0: t = 52'd0;
      1: t = 52'd1;
      2: t = 52'd2;
      default: t = 52'h8_0000_0000_0001;
    endcase
    return {t, 6'($urandom_range(0, 3)), 4'($urandom), 2'($urandom)};
  endfunction

  initial begin
    cif.addr = '0;
    cif.enable = 2'd0;
    cif.rd_wr_evict_flag = 2'd0;
    cif.bus_reqack = 1'b0;
    cif.bus_respcyc = 1'b0;
    cif.bus_resp = '0;
    cif.bus_resptag = '0;
    cif.addr_data_abtr_grant = 1'b0;
    cif.store_data_abtr_grant = 1'b0;
    m_clear();
    step();
    step();
    @(negedge clk);
    check_quiet("reset");
    step();
    reset = 1'b0;
    rd(64'h1004);
    rd(64'h1000);
    rd(64'h1000 + 64 * NS);
    rd(64'h1000);
    rd(64'h1000 + 128 * NS);
    rd(64'h1000);
    rd(64'h1000 + 64 * NS);
    evict(64'h1000);
    rd(64'h1000);
    evict(64'h1000);
    rd(64'h1000, 3);
    rd(64'h1000);
    rd(64'h103C);
    repeat (250) begin
      int r = $urandom_range(0, 19);
      logic [63:0] a = rand_addr();
      if (r < 12) rd(a, ($urandom_range(0, 24) == 0) ? $urandom_range(1, 7) : 8);
      else if (r < 15) evict(a);
      else noop(a);
    end
`ifdef CACHE_STATS_EN
    @(negedge clk);
    check("hit_count", 64'(hit_count), 64'(m_hits));
    check("miss_count", 64'(miss_count), 64'(m_miss));
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
